block_display: RTL

//  Pixel source for the VGA output stage. Converts the requested pixel_xpos/pixel_ypos into 12-bit RGB444 pixel_data.

---
 rtl/block_pkg.sv | 17 +
 rtl/block_board_ram.sv | 23 ++
 rtl/block_display.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/block_pkg.sv
// Shared colours and clear-sweep state encoding for the block-game playfield renderer.
package block_pkg;

    localparam logic [11:0] PALETTE [0:7] = '{
        12'h111, 12'h0FF, 12'h00F, 12'hF80,
        12'hFF0, 12'h0F0, 12'hF0F, 12'hF00
    };
    localparam logic [11:0] GRID_COLOR   = 12'h333;
    localparam logic [11:0] BORDER_COLOR = 12'hCCC;
    localparam logic [11:0] BG_COLOR     = 12'h012;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

endpackage

// File: rtl/block_board_ram.sv
// Board cell store: one write port, one registered read port; a same-address read returns the old data.
module block_board_ram #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/block_display.sv
// Playfield pixel source: board cells, falling-piece overlay, grid, border and background,
// with a one-cycle coordinate-to-pixel latency and per-frame piece latching.
module block_display
    import block_pkg::*;
#(
    parameter int CELL_LOG2  = 4,
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20,
    parameter int BOARD_X0   = 240,
    parameter int BOARD_Y0   = 80,
    parameter int BORDER_W   = 4
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pixel_xpos,
    input  logic [9:0]  pixel_ypos,
    output logic [11:0] pixel_data,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [2:0]  wr_color,
    input  logic        clr_req,
    output logic        clr_busy,
    input  logic [3:0]  piece_col,
    input  logic [4:0]  piece_row,
    input  logic [15:0] piece_mask,
    input  logic [2:0]  piece_color,
    output logic        frame_tick
);

    localparam int          CW        = 10 - CELL_LOG2;
    localparam logic [10:0] X_LO      = 11'(BOARD_X0);
    localparam logic [10:0] X_HI      = 11'(BOARD_X0 + (BOARD_COLS << CELL_LOG2));
    localparam logic [10:0] Y_LO      = 11'(BOARD_Y0);
    localparam logic [10:0] Y_HI      = 11'(BOARD_Y0 + (BOARD_ROWS << CELL_LOG2));
    localparam logic [10:0] BW        = 11'(BORDER_W);
    localparam logic [8:0]  NUM_CELLS = 9'(BOARD_COLS * BOARD_ROWS);
    localparam logic [7:0]  LAST_ADDR = 8'(BOARD_COLS * BOARD_ROWS - 1);

    // Geometry; 11-bit extension keeps the border comparisons free of wrap-around.
    logic [10:0]   x_ext, y_ext;
    logic          in_board, near_board, grid_hit, piece_hit;
    logic [9:0]    rx, ry;
    logic [CW-1:0] cell_col, cell_row, dr, dc;
    logic [7:0]    rd_addr;
    logic [15:0]   hit_vec;

    logic [3:0]  shadow_col_reg;
    logic [4:0]  shadow_row_reg;
    logic [15:0] shadow_mask_reg;
    logic [2:0]  shadow_color_reg;

    assign x_ext      = {1'b0, pixel_xpos};
    assign y_ext      = {1'b0, pixel_ypos};
    assign in_board   = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign near_board = (x_ext + BW >= X_LO) && (x_ext < X_HI + BW) &&
                        (y_ext + BW >= Y_LO) && (y_ext < Y_HI + BW);
    assign rx         = pixel_xpos - 10'(BOARD_X0);
    assign ry         = pixel_ypos - 10'(BOARD_Y0);
    assign cell_col   = rx[9:CELL_LOG2];
    assign cell_row   = ry[9:CELL_LOG2];
    assign rd_addr    = 8'(cell_row) * 8'(BOARD_COLS) + 8'(cell_col);
    assign grid_hit   = (rx[CELL_LOG2-1:0] == '0) || (ry[CELL_LOG2-1:0] == '0);

    // Offsets wrap to large values when the cell lies above/left of the piece, so they never match.
    assign dr = cell_row - CW'(shadow_row_reg);
    assign dc = cell_col - CW'(shadow_col_reg);

    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_piece
        assign hit_vec[gi] = shadow_mask_reg[gi] && (dr == CW'(gi / 4)) && (dc == CW'(gi % 4));
    end
    assign piece_hit = in_board && (|hit_vec);

    // Region flags registered alongside the RAM read.
    logic       valid_reg, piece_hit_reg, in_board_reg, grid_reg, near_reg;
    logic [2:0] piece_color_reg;
    logic [2:0] ram_rdata;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            valid_reg       <= 1'b0;
            piece_hit_reg   <= 1'b0;
            in_board_reg    <= 1'b0;
            grid_reg        <= 1'b0;
            near_reg        <= 1'b0;
            piece_color_reg <= '0;
        end else begin
            valid_reg       <= 1'b1;
            piece_hit_reg   <= piece_hit;
            in_board_reg    <= in_board;
            grid_reg        <= grid_hit;
            near_reg        <= near_board;
            piece_color_reg <= shadow_color_reg;
        end
    end

    always_comb begin
        pixel_data = BG_COLOR;
        if (!valid_reg) begin
            pixel_data = 12'h000;
        end else if (piece_hit_reg) begin
            pixel_data = PALETTE[piece_color_reg];
        end else if (in_board_reg && (ram_rdata != 3'd0)) begin
            pixel_data = PALETTE[ram_rdata];
        end else if (in_board_reg && grid_reg) begin
            pixel_data = GRID_COLOR;
        end else if (in_board_reg) begin
            pixel_data = PALETTE[0];
        end else if (near_reg) begin
            pixel_data = BORDER_COLOR;
        end
    end

    // End of the visible frame: piece state is latched only here so it never tears.
    logic vis_reg, frame_tick_reg, vis_fall;

    assign vis_fall   = vis_reg && (pixel_ypos == 10'd0);
    assign frame_tick = frame_tick_reg;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            vis_reg          <= 1'b0;
            frame_tick_reg   <= 1'b0;
            shadow_col_reg   <= '0;
            shadow_row_reg   <= '0;
            shadow_mask_reg  <= '0;
            shadow_color_reg <= '0;
        end else begin
            vis_reg        <= (pixel_ypos != 10'd0);
            frame_tick_reg <= vis_fall;
            if (vis_fall) begin
                shadow_col_reg   <= piece_col;
                shadow_row_reg   <= piece_row;
                shadow_mask_reg  <= piece_mask;
                shadow_color_reg <= piece_color;
            end
        end
    end

    // Clear sweep owns the write port while active.
    clr_state_t state_reg, state_next;
    logic [7:0] clr_addr_reg, clr_addr_next;
    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [2:0] ram_wdata;

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_next    = CLR_SWEEP;
                    clr_addr_next = 8'd0;
                end
            end
            CLR_SWEEP: begin
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next = CLR_IDLE;
                end else begin
                    clr_addr_next = clr_addr_reg + 8'd1;
                end
            end
            default: state_next = CLR_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_reg    <= CLR_IDLE;
            clr_addr_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    assign clr_busy  = (state_reg == CLR_SWEEP);
    assign ram_we    = !sys_rst && (clr_busy || (wr_en && ({1'b0, wr_addr} < NUM_CELLS)));
    assign ram_waddr = clr_busy ? clr_addr_reg : wr_addr;
    assign ram_wdata = clr_busy ? 3'd0 : wr_color;

    block_board_ram #(
        .DATA_W(3),
        .ADDR_W(8)
    ) u_board_ram (
        .clk  (vga_clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(rd_addr),
        .rdata(ram_rdata)
    );

endmodule
